// File: rtl/ca_row_writer_pkg.sv
// ca_row_writer_pkg: shared sizes, FSM states and byte extraction for the CA row writer.
package ca_row_writer_pkg;
  localparam int CELLS  = 128;
  localparam int BYTES  = 16;
  localparam int ROWS   = 64;
  localparam int ADDR_W = 10;

  typedef logic [CELLS-1:0] cells_t;
  typedef enum logic [1:0] {IDLE, WRITE, WAIT, STEP} state_t;

  // Cell 0 lives in bit 127, so byte k is the k-th octet counted from the top.
  function automatic logic [7:0] cell_byte(cells_t c, logic [3:0] k);
    return 8'(c >> {~k, 3'b000});
  endfunction
endpackage

// File: rtl/ca_row_writer_step.sv
// ca_row_writer_step: combinational next-generation logic for one 128-cell row.
module ca_row_writer_step
  import ca_row_writer_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  cells_t     i_cells,
  input  logic [7:0] i_rule,
  output cells_t     o_next
);
  logic [CELLS+1:0] w_ext;
  // Pad both ends so every cell sees {left, self, right} as three adjacent bits.
  assign w_ext = {(WRAP != 0) & i_cells[0], i_cells, (WRAP != 0) & i_cells[CELLS-1]};
  for (genvar g = 0; g < CELLS; g++) begin : g_cell
    assign o_next[g] = i_rule[w_ext[g +: 3]];
  end
endmodule

// File: rtl/ca_row_writer.sv
// ca_row_writer: tick-paced elementary cellular automaton that writes 64 generations
// of 16 bytes each into the debug RAM write port.
module ca_row_writer
  import ca_row_writer_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rule,
  input  logic              i_seed_sel,
  input  logic              i_tick,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_din,
  output logic              o_busy,
  output logic              o_done,
  output logic [5:0]        o_gen
);
  state_t     r_state;
  cells_t     r_cells;
  cells_t     w_next;
  cells_t     w_seed;
  logic [7:0] r_rule;
  logic [5:0] r_gen;
  logic       r_pend;
  logic       w_go;

  assign w_seed = i_seed_sel ? {1'b1, 127'b0} : {64'b0, 1'b1, 63'b0};
  assign w_go   = r_pend | i_tick;
  assign o_gen  = r_gen;

  ca_row_writer_step #(.WRAP(WRAP)) u_step (
    .i_cells(r_cells),
    .i_rule (r_rule),
    .o_next (w_next)
  );

  // The output registers always hold the byte being written this cycle; the
  // column currently on the bus is o_ram_addr[3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cells    <= '0;
      r_rule     <= '0;
      r_gen      <= '0;
      r_pend     <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      r_pend <= (r_state == WRITE || r_state == STEP) && w_go;
      case (r_state)
        IDLE: if (i_start) begin
          r_rule     <= i_rule;
          r_cells    <= w_seed;
          r_gen      <= '0;
          o_busy     <= 1'b1;
          o_ram_we   <= 1'b1;
          o_ram_addr <= '0;
          o_ram_din  <= cell_byte(w_seed, 4'd0);
          r_state    <= WRITE;
        end
        WRITE: if (o_ram_addr[3:0] == 4'(BYTES-1)) begin
          o_ram_we <= 1'b0;
          if (r_gen == 6'(ROWS-1)) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end else begin
          o_ram_addr <= o_ram_addr + 10'd1;
          o_ram_din  <= cell_byte(r_cells, o_ram_addr[3:0] + 4'd1);
        end
        WAIT: if (w_go) r_state <= STEP;
        STEP: begin
          r_cells    <= w_next;
          r_gen      <= r_gen + 6'd1;
          o_ram_we   <= 1'b1;
          o_ram_addr <= {r_gen + 6'd1, 4'd0};
          o_ram_din  <= cell_byte(w_next, 4'd0);
          r_state    <= WRITE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ca_row_writer.sv
// tb_ca_row_writer: directed bench with a cell-array reference model of the automaton
// checking every RAM write of a wrapping and a non-wrapping instance.
module tb_ca_row_writer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_rule = 8'd0;
  logic       i_seed_sel = 1'b0;
  logic       i_tick = 1'b0;

  logic       w1_we, w1_busy, w1_done, w0_we, w0_busy, w0_done;
  logic [9:0] w1_addr, w0_addr;
  logic [7:0] w1_din, w0_din;
  logic [5:0] w1_gen, w0_gen;

  always #5 clk = ~clk;

  ca_row_writer #(.WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_rule(i_rule), .i_seed_sel(i_seed_sel),
    .i_tick(i_tick), .o_ram_we(w1_we), .o_ram_addr(w1_addr), .o_ram_din(w1_din),
    .o_busy(w1_busy), .o_done(w1_done), .o_gen(w1_gen)
  );

  ca_row_writer #(.WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_rule(i_rule), .i_seed_sel(i_seed_sel),
    .i_tick(i_tick), .o_ram_we(w0_we), .o_ram_addr(w0_addr), .o_ram_din(w0_din),
    .o_busy(w0_busy), .o_done(w0_done), .o_gen(w0_gen)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic ck(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: index i is cell i (cell 0 leftmost).
  logic [7:0]   s_rule;
  logic         s_seed;
  int           run_id = 0;
  int           seen_id = 0;
  logic [0:127] m_cells [2];
  logic [5:0]   m_row [2];
  logic [3:0]   m_col [2];
  logic [7:0]   m_rule;
  logic [7:0]   ram [2][1024];
  int           we_cnt = 0;
  int           done_cnt = 0;

  function automatic logic [0:127] next_gen(logic [0:127] c, logic [7:0] r, bit wrap);
    logic [0:127] n;
    logic         l, rt;
    for (int i = 0; i < 128; i++) begin
      l    = (i == 0)   ? (wrap & c[127]) : c[i-1];
      rt   = (i == 127) ? (wrap & c[0])   : c[i+1];
      n[i] = r[{l, c[i], rt}];
    end
    return n;
  endfunction

  task automatic model_write(int u, logic [9:0] a, logic [7:0] d, bit wrap);
    ck($sformatf("addr_u%0d", u), a, {m_row[u], m_col[u]});
    ck($sformatf("data_u%0d_%03h", u, a), d, m_cells[u][8*m_col[u] +: 8]);
    ram[u][a] = d;
    if (m_col[u] == 4'd15) begin
      m_row[u]++;
      m_cells[u] = next_gen(m_cells[u], m_rule, wrap);
    end
    m_col[u]++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (run_id != seen_id) begin
        seen_id = run_id;
        m_rule  = s_rule;
        for (int u = 0; u < 2; u++) begin
          m_cells[u] = '0;
          m_cells[u][s_seed ? 0 : 64] = 1'b1;
          m_row[u] = '0;
          m_col[u] = '0;
        end
      end
      if (w1_we) begin
        we_cnt++;
        model_write(0, w1_addr, w1_din, 1'b1);
      end
      if (w0_we) model_write(1, w0_addr, w0_din, 1'b0);
      if (w1_done) done_cnt++;
    end
  end

  int we_base, done_base, bad;

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick1;
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
  endtask

  task automatic wait_we(logic v, string nm);
    int k = 0;
    while (w1_we !== v && k < 40) begin
      cyc(1);
      k++;
    end
    ck(nm, w1_we, v);
  endtask

  task automatic do_start(logic [7:0] r, logic s);
    s_rule = r;
    s_seed = s;
    run_id++;
    we_base = we_cnt;
    done_base = done_cnt;
    i_rule = r;
    i_seed_sel = s;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    ck("first_we", w1_we, 1);
    ck("first_addr", w1_addr, 0);
    ck("busy_on", w1_busy, 1);
  endtask

  task automatic finish_run;
    for (int r = 0; r < 64; r++) begin
      wait_we(1'b0, "row_end");
      if (w1_gen == 6'd63) break;
      tick1;
      wait_we(1'b1, "row_go");
    end
    ck("done_pulse", w1_done, 1);
    ck("busy_off", w1_busy, 0);
    cyc(1);
    ck("done_1cyc", w1_done, 0);
    ck("we_total", we_cnt - we_base, 1024);
    ck("done_cnt", done_cnt - done_base, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    ck("rst_we", w1_we, 0);
    ck("rst_addr", w1_addr, 0);
    ck("rst_din", w1_din, 0);
    ck("rst_busy", w1_busy, 0);
    ck("rst_done", w1_done, 0);
    ck("rst_gen", w1_gen, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Centre seed, rule 90
    do_start(8'd90, 1'b0);
    wait_we(1'b0, "s1_r0_end");
    for (int k = 0; k < 16; k++)
      ck($sformatf("s1_r0_b%0d", k), ram[0][k], (k == 8) ? 8'h80 : 8'h00);
    tick1;
    wait_we(1'b1, "s1_r1_go");
    wait_we(1'b0, "s1_r1_end");
    ck("s1_017", ram[0][10'h017], 8'h01);
    ck("s1_018", ram[0][10'h018], 8'h40);
    finish_run;

    // Edge seed, rule 90, both edge modes
    do_start(8'd90, 1'b1);
    wait_we(1'b0, "s2_r0_end");
    tick1;
    wait_we(1'b1, "s2_r1_go");
    wait_we(1'b0, "s2_r1_end");
    ck("s2_w_010", ram[0][10'h010], 8'h40);
    ck("s2_w_01f", ram[0][10'h01F], 8'h01);
    ck("s2_n_010", ram[1][10'h010], 8'h40);
    ck("s2_n_01f", ram[1][10'h01F], 8'h00);
    finish_run;

    // Constant rules
    for (int t = 0; t < 2; t++) begin
      do_start(t == 0 ? 8'hFF : 8'h00, 1'b0);
      finish_run;
      bad = 0;
      for (int a = 16; a < 1024; a++)
        if (ram[0][a] !== (t == 0 ? 8'hFF : 8'h00)) bad++;
      ck($sformatf("s3_rows_rule%0d", t == 0 ? 255 : 0), bad, 0);
    end

    // Start while busy is ignored
    do_start(8'd90, 1'b0);
    cyc(2);
    i_rule = 8'd30;
    i_seed_sel = 1'b1;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    ck("s5_busy", w1_busy, 1);
    finish_run;
    ck("s5_017", ram[0][10'h017], 8'h01);
    ck("s5_018", ram[0][10'h018], 8'h40);
    cyc(1);

    // Pacing: three ticks during row 0 give exactly one step
    do_start(8'd30, 1'b0);
    tick1;
    cyc(1);
    tick1;
    cyc(1);
    tick1;
    wait_we(1'b0, "s4_r0_end");
    wait_we(1'b1, "s4_r1_auto");
    ck("s4_gen1", w1_gen, 1);
    wait_we(1'b0, "s4_r1_end");
    bad = we_cnt;
    cyc(30);
    ck("s4_no_row2", we_cnt - bad, 0);
    ck("s4_gen_hold", w1_gen, 1);
    tick1;
    wait_we(1'b1, "s4_r2_go");
    ck("s4_gen2", w1_gen, 2);
    for (int r = 3; r < 6; r++) begin
      wait_we(1'b0, "s6_row_end");
      tick1;
      wait_we(1'b1, "s6_row_go");
    end
    ck("s6_gen5", w1_gen, 5);

    // Asynchronous reset during the row-5 write
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    ck("s6_we", w1_we, 0);
    ck("s6_busy", w1_busy, 0);
    ck("s6_gen", w1_gen, 0);
    ck("s6_addr", w1_addr, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    do_start(8'd150, 1'b1);
    finish_run;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
